// File: rtl/pcpi_pkg.sv
// Shared types and defaults for the PCPI initiator and its timeout counter.
package pcpi_pkg;

    localparam int PCPI_XLEN    = 32;
    localparam int PCPI_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } pcpi_state_e;

    typedef struct packed {
        logic [PCPI_XLEN-1:0] insn;
        logic [PCPI_XLEN-1:0] rs1;
        logic [PCPI_XLEN-1:0] rs2;
    } pcpi_req_t;

    typedef struct packed {
        logic                 wr;
        logic [PCPI_XLEN-1:0] rd;
        logic                 illegal;
    } pcpi_rsp_t;

    // A zero timeout still needs a 1-bit counter so the logic stays well formed.
    function automatic int ctr_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Clear-on-wait saturating counter; fire pulses on the last no-wait cycle
// of an unanswered request. TIMEOUT_CYCLES=0 never fires.
module pcpi_timeout_ctr
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PCPI_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stall,
    input  logic ready_in,
    output logic fire
);

    localparam int             CW       = ctr_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic           EN       = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!active || stall) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A same-cycle ready always beats the timeout.
    assign fire = EN && active && !stall && !ready_in && (cnt == CNT_LAST);

endmodule

// File: rtl/pcpi_initiator.sv
// PCPI master: issues one instruction at a time and returns the responder's
// result. Optional perf counters enabled by PCPI_INITIATOR_PERF_EN.
module pcpi_initiator
    import pcpi_pkg::*;
#(
    parameter int XLEN           = PCPI_XLEN,
    parameter int TIMEOUT_CYCLES = PCPI_TIMEOUT
) (
    input  logic            pcpi_clock,
    input  logic            pcpi_reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_insn,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_wr,
    output logic [XLEN-1:0] rsp_rd,
    output logic            rsp_illegal,
    output logic            pcpi_valid,
    output logic [XLEN-1:0] pcpi_insn,
    output logic [XLEN-1:0] pcpi_rs1,
    output logic [XLEN-1:0] pcpi_rs2,
    input  logic            pcpi_wr,
    input  logic [XLEN-1:0] pcpi_rd,
    input  logic            pcpi_wait,
    input  logic            pcpi_ready
`ifdef PCPI_INITIATOR_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_illegal,
    output logic [31:0]     perf_busy
`endif
);

    pcpi_state_e state, state_nxt;
    logic        in_issue;
    logic        fire;

    assign in_issue = (state == ISSUE);

    pcpi_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (pcpi_clock),
        .rst      (pcpi_reset),
        .active   (in_issue),
        .stall    (pcpi_wait),
        .ready_in (pcpi_ready),
        .fire     (fire)
    );

    always_ff @(posedge pcpi_clock or posedge pcpi_reset) begin
        if (pcpi_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        pcpi_valid = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                pcpi_valid = 1'b1;
                if (pcpi_ready || fire) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request and response registers; responder inputs only matter in ISSUE.
    always_ff @(posedge pcpi_clock or posedge pcpi_reset) begin
        if (pcpi_reset) begin
            pcpi_insn   <= '0;
            pcpi_rs1    <= '0;
            pcpi_rs2    <= '0;
            rsp_wr      <= 1'b0;
            rsp_rd      <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                pcpi_insn <= req_insn;
                pcpi_rs1  <= req_rs1;
                pcpi_rs2  <= req_rs2;
            end
            if (in_issue) begin
                if (pcpi_ready) begin
                    rsp_wr      <= pcpi_wr;
                    rsp_rd      <= pcpi_wr ? pcpi_rd : '0;
                    rsp_illegal <= 1'b0;
                end else if (fire) begin
                    rsp_wr      <= 1'b0;
                    rsp_rd      <= '0;
                    rsp_illegal <= 1'b1;
                end
            end
        end
    end

`ifdef PCPI_INITIATOR_PERF_EN
    always_ff @(posedge pcpi_clock or posedge pcpi_reset) begin
        if (pcpi_reset) begin
            perf_issued  <= '0;
            perf_illegal <= '0;
            perf_busy    <= '0;
        end else begin
            if (state == IDLE && req_valid) perf_issued  <= perf_issued + 32'd1;
            if (fire)                       perf_illegal <= perf_illegal + 32'd1;
            if (in_issue)                   perf_busy    <= perf_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
// Directed bench for pcpi_initiator with a response scoreboard.
module tb_pcpi_initiator;
    import pcpi_pkg::*;

    localparam int XLEN = 32;

    logic            pcpi_clock = 1'b0;
    logic            pcpi_reset = 1'b1;
    logic            req_valid  = 1'b0;
    logic            req_ready;
    logic [XLEN-1:0] req_insn   = '0;
    logic [XLEN-1:0] req_rs1    = '0;
    logic [XLEN-1:0] req_rs2    = '0;
    logic            rsp_valid;
    logic            rsp_ready  = 1'b1;
    logic            rsp_wr;
    logic [XLEN-1:0] rsp_rd;
    logic            rsp_illegal;
    logic            pcpi_valid;
    logic [XLEN-1:0] pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_wr    = 1'b0;
    logic [XLEN-1:0] pcpi_rd    = '0;
    logic            pcpi_wait  = 1'b0;
    logic            pcpi_ready = 1'b0;
`ifdef PCPI_INITIATOR_PERF_EN
    logic [31:0]     perf_issued, perf_illegal, perf_busy;
`endif

    pcpi_initiator #(.XLEN(XLEN), .TIMEOUT_CYCLES(16)) dut (
        .pcpi_clock (pcpi_clock),
        .pcpi_reset (pcpi_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_wr     (rsp_wr),
        .rsp_rd     (rsp_rd),
        .rsp_illegal(rsp_illegal),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
`ifdef PCPI_INITIATOR_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_illegal(perf_illegal),
        .perf_busy   (perf_busy)
`endif
    );

    always #5 pcpi_clock = ~pcpi_clock;

    int        n_assert = 0;
    int        n_fail   = 0;
    int        pv_cnt   = 0;
    pcpi_rsp_t exp_q[$];

    always @(posedge pcpi_clock) if (pcpi_valid === 1'b1) pv_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pcpi_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request from IDLE; returns in the first ISSUE cycle.
    task automatic send_req(input string tag, input logic [XLEN-1:0] insn,
                            input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
        chk({tag, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        tick();
        req_valid = 1'b0;
        req_insn  = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        chk({tag, "_pcpi_valid"}, pcpi_valid, 1);
        chk({tag, "_pcpi_insn"}, pcpi_insn, insn);
        chk({tag, "_pcpi_ops"}, {pcpi_rs1, pcpi_rs2}, {rs1, rs2});
    endtask

    // Responder answers this cycle; expected result is pushed to the scoreboard.
    task automatic pulse_ready(input logic wr, input logic [XLEN-1:0] rd);
        pcpi_rsp_t e;
        e.wr      = wr;
        e.rd      = wr ? rd : '0;
        e.illegal = 1'b0;
        exp_q.push_back(e);
        pcpi_ready = 1'b1;
        pcpi_wr    = wr;
        pcpi_rd    = rd;
        tick();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
    endtask

    task automatic push_illegal();
        pcpi_rsp_t e;
        e.wr      = 1'b0;
        e.rd      = '0;
        e.illegal = 1'b1;
        exp_q.push_back(e);
    endtask

    // Wait for a response, compare against the scoreboard head, then consume it.
    task automatic get_rsp(input string tag);
        pcpi_rsp_t e;
        int        n = 0;
        while (rsp_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_seen"}, rsp_valid, 1);
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_rsp_wr"}, rsp_wr, e.wr);
                chk({tag, "_rsp_rd"}, rsp_rd, e.rd);
                chk({tag, "_rsp_illegal"}, rsp_illegal, e.illegal);
            end
            chk({tag, "_pv_low_resp"}, pcpi_valid, 0);
            rsp_ready = 1'b1;
            tick();
            chk({tag, "_rsp_done"}, rsp_valid, 0);
            chk({tag, "_pv_low_idle"}, pcpi_valid, 0);
        end
    endtask

    initial begin
        int k;
        int pv0;
        logic early;

        // Reset state
        repeat (2) @(posedge pcpi_clock);
        #1;
        chk("rst_pcpi_valid", pcpi_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_wr, rsp_illegal, rsp_rd}, 0);
        chk("rst_pcpi_regs", {pcpi_insn, pcpi_rs1, pcpi_rs2}, 0);
        pcpi_reset = 1'b0;
        tick();
        chk("rst_req_ready", req_ready, 1);
`ifdef PCPI_INITIATOR_PERF_EN
        chk("rst_perf", {perf_issued, perf_illegal, perf_busy}, 0);
`endif

        // Basic write: answer on the third ISSUE cycle
        pv0 = pv_cnt;
        send_req("basic", 32'h0000_000B, 32'd5, 32'd7);
        chk("basic_req_ready_busy", req_ready, 0);
        tick();
        tick();
        pulse_ready(1'b1, 32'd12);
        get_rsp("basic");
        chk("basic_pv_cycles", pv_cnt - pv0, 3);
`ifdef PCPI_INITIATOR_PERF_EN
        chk("perf_basic", {perf_issued, perf_illegal, perf_busy}, {32'd1, 32'd0, 32'd3});
`endif

        // No-write: rd must be masked to zero
        send_req("nowr", 32'h0000_002B, 32'd1, 32'd2);
        pulse_ready(1'b0, 32'hDEAD);
        get_rsp("nowr");

        // Timeout with no responder
        send_req("tmo", 32'h0000_005B, 32'd3, 32'd4);
        push_illegal();
        k = 0;
        while (rsp_valid !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        chk("tmo_latency", k, 16);
        get_rsp("tmo");

        // Wait extension: 40 busy cycles then a legal answer
        send_req("wait", 32'h0000_007B, 32'd8, 32'd9);
        pcpi_wait = 1'b1;
        early = 1'b0;
        repeat (40) begin
            tick();
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        chk("wait_no_timeout", early, 0);
        pcpi_wait = 1'b0;
        pulse_ready(1'b1, 32'h55);
        get_rsp("wait");

        // Ready on the 16th no-wait cycle coincides with the timeout: ready wins
        send_req("edge", 32'h0000_000B, 32'd10, 32'd11);
        early = 1'b0;
        repeat (15) begin
            tick();
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        chk("edge_no_early", early, 0);
        pulse_ready(1'b1, 32'hAA);
        get_rsp("edge");

        // A single wait cycle restarts the timeout window
        send_req("refresh", 32'h0000_000B, 32'd12, 32'd13);
        push_illegal();
        repeat (10) tick();
        pcpi_wait = 1'b1;
        tick();
        pcpi_wait = 1'b0;
        k = 11;
        while (rsp_valid !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        chk("refresh_latency", k, 27);
        get_rsp("refresh");

        // Backpressure: response holds, stray pcpi_ready is ignored
        rsp_ready = 1'b0;
        send_req("bp", 32'h0000_000B, 32'd14, 32'd15);
        tick();
        pulse_ready(1'b1, 32'h1234);
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'hFFFF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rd", rsp_rd, 32'h1234);
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        get_rsp("bp");

        // Back-to-back requests, in-order responses
        for (int i = 0; i < 3; i++) begin
            send_req("b2b", 32'h100 + i, i, 2 * i);
            pulse_ready(1'b1, 32'd100 + i);
            get_rsp("b2b");
        end

        // Reset in the second ISSUE cycle aborts silently
        send_req("rstmid", 32'h0000_000B, 32'd20, 32'd21);
        tick();
        pcpi_reset = 1'b1;
        #1;
        chk("rstmid_pcpi_valid", pcpi_valid, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_pcpi_insn", pcpi_insn, 0);
        tick();
        pcpi_reset = 1'b0;
        early = 1'b0;
        repeat (3) begin
            tick();
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        chk("rstmid_no_rsp", early, 0);
`ifdef PCPI_INITIATOR_PERF_EN
        chk("rstmid_perf", {perf_issued, perf_illegal, perf_busy}, 0);
`endif
        send_req("after_rst", 32'h0000_000B, 32'd30, 32'd31);
        tick();
        pulse_ready(1'b1, 32'd61);
        get_rsp("after_rst");
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pcpi_initiator.md
Name: pcpi_initiator

Overview:
- CPU-side master for the PCPI co-processor interface; issues one custom instruction at a time to a PCPI responder and returns its result.
- Upstream side is a valid/ready request port carrying insn/rs1/rs2. Downstream side is a valid/ready response port carrying wr/rd plus an illegal-instruction flag.
- Sits between a core's decode/execute stage, or a test driver, and any PCPI_IF responder. Implements hold-until-ready issue and the wait-extended timeout.

Parameters:
- XLEN, 32, width of insn, rs1, rs2 and rd.
- TIMEOUT_CYCLES, 16, consecutive no-wait cycles before an unanswered request is declared illegal; 0 disables the timeout.

Ports:
- pcpi_clock  in  1  clock; all state on rising edge.
- pcpi_reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  upstream request present.
- req_ready  out  1  initiator can accept a request.
- req_insn  in  XLEN  instruction word.
- req_rs1  in  XLEN  operand 1.
- req_rs2  in  XLEN  operand 2.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  upstream consumes response.
- rsp_wr  out  1  responder requested a register write.
- rsp_rd  out  XLEN  result value; 0 when rsp_wr=0.
- rsp_illegal  out  1  request timed out with no responder.
- pcpi_valid  out  1  request asserted to responder.
- pcpi_insn  out  XLEN  registered instruction.
- pcpi_rs1  out  XLEN  registered operand 1.
- pcpi_rs2  out  XLEN  registered operand 2.
- pcpi_wr  in  1  responder write flag; sampled with pcpi_ready.
- pcpi_rd  in  XLEN  responder result; sampled with pcpi_ready.
- pcpi_wait  in  1  responder is busy; suppresses timeout.
- pcpi_ready  in  1  responder finished.

Behaviour:
- Reset (async, immediate): state=IDLE; outputs pcpi_valid=0, rsp_valid=0, rsp_wr=0, rsp_illegal=0, rsp_rd=0, pcpi_insn/rs1/rs2=0; timeout counter=0.
- Reset mid-transaction aborts it silently; no response is produced.
- FSM has three states: IDLE, ISSUE, RESP.
  - IDLE: req_ready=1. If req_valid, capture insn/rs1/rs2 into the pcpi_* registers, clear the counter, go to ISSUE.
  - ISSUE: pcpi_valid=1; insn/rs1/rs2 are held stable; req_ready=0. pcpi_ready/pcpi_wr/pcpi_rd are sampled only in ISSUE.
    - If pcpi_ready: latch rsp_wr=pcpi_wr, rsp_rd=(pcpi_wr ? pcpi_rd : 0), rsp_illegal=0; go to RESP.
    - Else if the timeout fires: rsp_wr=0, rsp_rd=0, rsp_illegal=1; go to RESP.
  - RESP: rsp_valid=1, pcpi_valid=0. On rsp_ready, go to IDLE and clear rsp_valid.
- Latency:
  - Request accepted at edge N gives pcpi_valid=1 from cycle N+1.
  - pcpi_ready sampled at edge M gives rsp_valid=1 and pcpi_valid=0 in cycle M+1.
  - Minimum round trip is 2 cycles. pcpi_valid is low for at least 2 cycles between back-to-back requests (RESP, then IDLE).
- Timeout counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - In ISSUE it resets to 0 on any cycle with pcpi_wait=1; otherwise it increments, saturating.
  - The timeout fires when the counter equals TIMEOUT_CYCLES-1 and pcpi_wait=0 and pcpi_ready=0, i.e. after exactly TIMEOUT_CYCLES consecutive no-wait cycles.
- Same-cycle ready and timeout: ready wins and the response is legal. pcpi_ready together with pcpi_wait: ready wins.
- pcpi_ready outside ISSUE is ignored.
- Response outputs hold stable while rsp_valid=1 and rsp_ready=0.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: PCPI_INITIATOR_PERF_EN.
- When defined, adds outputs perf_issued (32), perf_illegal (32) and perf_busy (32), all reset to 0 and wrapping modulo 2^32:
  - perf_issued increments on each IDLE→ISSUE transition.
  - perf_illegal increments on each timeout.
  - perf_busy increments on every ISSUE cycle.
- When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package pcpi_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - XLEN default;
  - default timeout of 16;
  - the typedef pcpi_req_t {insn, rs1, rs2};
  - the typedef pcpi_rsp_t {wr, rd, illegal}.
- One natural sub-module, pcpi_timeout_ctr, implements the clear-on-wait saturating counter and fire pulse, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Basic write: req insn=0x0000000B, rs1=5, rs2=7; responder answers wr=1, rd=12 after 3 cycles → one rsp with wr=1, rd=12, illegal=0; pcpi_valid high exactly 3 cycles.
- No-write: responder returns ready with wr=0 and rd=0xDEAD → rsp_wr=0, rsp_rd=0, illegal=0.
- Timeout: no responder (ready=0, wait=0) → rsp_illegal=1 exactly 16 cycles after pcpi_valid rises; rsp_wr=0.
- Wait extension: wait=1 for 40 cycles, then ready with rd=0x55 → no timeout; rsp_rd=0x55, illegal=0. A boundary case with ready arriving on cycle 16 of no-wait → legal response.
- Backpressure and back-to-back: hold rsp_ready=0 for 5 cycles → rsp stable and req_ready=0; then issue 3 requests with rsp_ready=1 → 3 in-order responses, pcpi_valid low ≥2 cycles between them.
- Reset mid-ISSUE: assert pcpi_reset in cycle 2 of ISSUE → pcpi_valid=0 immediately; no rsp_valid; the next request completes normally. With PCPI_INITIATOR_PERF_EN, counters read 0 after reset.
